// File: rtl/dac_sample_sched.sv
// Paced sample scheduler feeding the 10-bit avsddac D bus from a small FIFO.
// Optional slew limiting of D is built when DAC_SLEW_EN is defined.
module dac_sample_sched #(
    parameter int DW       = 10,
    parameter int DEPTH    = 8,
    parameter int DIV_W    = 16,
    parameter int MIDSCALE = 512,
    parameter int MAX_STEP = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     en,
    input  logic [DIV_W-1:0]         div,
    input  logic [DW-1:0]            s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DW-1:0]            D,
    output logic                     upd,
    output logic                     underflow,
    input  logic                     clr_uf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DW-1:0] MID = DW'(MIDSCALE);

    if (MAX_STEP < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_chk
        $error("dac_sample_sched: bad DEPTH or MAX_STEP");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e            state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DW-1:0]     d_q, d_d;
    logic              upd_q;
    logic              uf_q;
    logic [LW-1:0]     lvl_q, lvl_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]     mem_q [DEPTH];

    logic full, empty, tick, push, pop, uf_set;
    logic [DW-1:0] head;

    assign full    = (lvl_q == LW'(DEPTH));
    assign empty   = (lvl_q == '0);
    assign s_ready = !full;
    assign push    = s_valid && !full;
    assign tick    = (state_q == RUN) && en && (cnt_q == '0);
    assign head    = mem_q[rd_ptr_q];

`ifdef DAC_SLEW_EN
    localparam logic [DW-1:0] STEP = DW'(MAX_STEP);

    logic [DW-1:0] tgt_q, tgt_d;

    function automatic logic [DW-1:0] step_to(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] tgt);
        logic [DW-1:0] res;
        res = tgt;
        if (tgt > cur) begin
            if (tgt - cur > STEP) res = cur + STEP;
        end else if (cur > tgt) begin
            if (cur - tgt > STEP) res = cur - STEP;
        end
        return res;
    endfunction

    // Only fetch a new target once D has settled on the previous one.
    assign pop    = tick && !empty && (d_q == tgt_q);
    assign uf_set = tick && empty && (d_q == tgt_q);
    assign tgt_d  = pop ? head : tgt_q;
    assign d_d    = step_to(d_q, tgt_d);
`else
    assign pop    = tick && !empty;
    assign uf_set = tick && empty;
    assign d_d    = pop ? head : d_q;
`endif

    always_comb begin
        lvl_d = lvl_q;
        unique case ({push, pop})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            d_q      <= MID;
            upd_q    <= 1'b0;
            uf_q     <= 1'b0;
            lvl_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef DAC_SLEW_EN
            tgt_q    <= MID;
`endif
        end else begin
            upd_q <= 1'b0;
            lvl_q <= lvl_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (uf_set)      uf_q <= 1'b1;
            else if (clr_uf) uf_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= RUN;
                        cnt_q   <= div;
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Leaving RUN drops any pending tick and parks D.
                        state_q <= IDLE;
                        d_q     <= MID;
`ifdef DAC_SLEW_EN
                        tgt_q   <= MID;
`endif
                    end else if (tick) begin
                        cnt_q <= div;
                        upd_q <= 1'b1;
                        d_q   <= d_d;
`ifdef DAC_SLEW_EN
                        tgt_q <= tgt_d;
`endif
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign D         = d_q;
    assign upd       = upd_q;
    assign underflow = uf_q;
    assign level     = lvl_q;

endmodule
